// File: rtl/lockstep_mode_ctrl.sv
// Lockstep mode sequencer: a peripheral-bus register block that moves core pairs into and
// out of lockstep, switching only when every core of the selected pairs meets at a barrier.
module lockstep_mode_ctrl #(
  parameter int NUM_CORES = 8,
  parameter int NUM_PAIRS = NUM_CORES / 2,
  parameter int ID_WIDTH  = 2,
  parameter int TO_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [31:0]          add_i,
  input  logic                 wen_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  input  logic [ID_WIDTH-1:0]  id_i,
  output logic                 gnt_o,
  output logic                 r_valid_o,
  output logic                 r_opc_o,
  output logic [ID_WIDTH-1:0]  r_id_o,
  output logic [31:0]          r_rdata_o,
  input  logic [NUM_CORES-1:0] barrier_matched_i,
  output logic                 lockstep_mode_o,
  output logic [NUM_PAIRS-1:0] lockstep_pairs_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC_IN  = 2'd1,
    LOCKED   = 2'd2,
    SYNC_OUT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_PAIRS-1:0]  mask_q, mask_d;
  logic [TO_WIDTH-1:0]   timeout_q, timeout_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [7:0]            errcnt_q, errcnt_d;
  logic                  irq_q;
  logic                  r_valid_q, r_opc_q, r_opc_d;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [31:0]           r_rdata_q, r_rdata_d;

  logic [3:0]            reg_sel;
  logic                  wr_en, rd_en, ctrl_wr, cmd_enter, cmd_exit;
  logic                  enter_ok, exit_ok, ctrl_bad, bad_addr;
  logic [NUM_PAIRS-1:0]  cmd_mask;
  logic [NUM_CORES-1:0]  core_mask;
  logic                  in_sync, sync_match, to_fire;
  logic [31:0]           be_bits, status_word;
  logic                  unused_bits;

  assign unused_bits = ^{add_i, wdata_i, be_i};

  assign reg_sel   = add_i[5:2];
  assign wr_en     = req_i & ~wen_i;
  assign rd_en     = req_i & wen_i;
  assign ctrl_wr   = wr_en && (reg_sel == 4'd0);
  assign cmd_enter = wdata_i[0];
  assign cmd_exit  = wdata_i[1];
  assign cmd_mask  = wdata_i[NUM_PAIRS+7:8];

  assign enter_ok = ctrl_wr && cmd_enter && !cmd_exit && (state_q == IDLE) && (|cmd_mask);
  assign exit_ok  = ctrl_wr && cmd_exit && !cmd_enter && (state_q == LOCKED);
  assign ctrl_bad = ctrl_wr && (cmd_enter || cmd_exit) && !enter_ok && !exit_ok;
  assign bad_addr = req_i && (reg_sel > 4'd3);

  // Each pair bit qualifies both of its cores; unmasked cores always read as matched.
  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_core_mask
    assign core_mask[2*p +: 2] = {2{mask_q[p]}};
  end

  assign in_sync    = (state_q == SYNC_IN) || (state_q == SYNC_OUT);
  assign sync_match = &(barrier_matched_i | ~core_mask);
  assign cnt_inc    = cnt_q + 1'b1;
  // A match in the same cycle suppresses the timeout.
  assign to_fire    = in_sync && !sync_match && (timeout_q != '0) && (cnt_inc == timeout_q);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    else         state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enter_ok)   state_d = SYNC_IN;
      SYNC_IN:  if (sync_match) state_d = LOCKED;
                else if (to_fire) state_d = IDLE;
      LOCKED:   if (exit_ok)    state_d = SYNC_OUT;
      SYNC_OUT: if (sync_match) state_d = IDLE;
                else if (to_fire) state_d = LOCKED;
      default:  state_d = IDLE;
    endcase
  end

  // FSM: outputs; pairs stay enabled until the exit handshake completes.
  always_comb begin
    lockstep_pairs_o = '0;
    lockstep_mode_o  = 1'b0;
    if ((state_q == LOCKED) || (state_q == SYNC_OUT)) begin
      lockstep_pairs_o = mask_q;
      lockstep_mode_o  = |mask_q;
    end
  end

  assign be_bits = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  always_comb begin
    status_word                  = '0;
    status_word[1:0]             = state_q;
    status_word[NUM_PAIRS+7:8]   = mask_q;

    mask_d    = enter_ok ? cmd_mask : mask_q;
    cnt_d     = (in_sync && !sync_match && !to_fire) ? cnt_inc : '0;

    timeout_d = timeout_q;
    if (wr_en && (reg_sel == 4'd2))
      timeout_d = (timeout_q & ~be_bits[TO_WIDTH-1:0]) | (wdata_i[TO_WIDTH-1:0] & be_bits[TO_WIDTH-1:0]);

    errcnt_d = errcnt_q;
    if (wr_en && (reg_sel == 4'd3))       errcnt_d = '0;
    else if (to_fire && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;

    r_rdata_d = '0;
    if (rd_en) begin
      unique case (reg_sel)
        4'd1:    r_rdata_d = status_word;
        4'd2:    r_rdata_d[TO_WIDTH-1:0] = timeout_q;
        4'd3:    r_rdata_d[7:0] = errcnt_q;
        default: r_rdata_d = '0;
      endcase
    end
    r_opc_d = bad_addr || ctrl_bad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q    <= '0;
      timeout_q <= '0;
      cnt_q     <= '0;
      errcnt_q  <= '0;
      irq_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_id_q    <= '0;
      r_rdata_q <= '0;
    end else begin
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      errcnt_q  <= errcnt_d;
      irq_q     <= to_fire;
      r_valid_q <= req_i;
      r_opc_q   <= req_i & r_opc_d;
      r_rdata_q <= r_rdata_d;
      if (req_i) r_id_q <= id_i;
    end
  end

  assign gnt_o     = req_i;
  assign r_valid_o = r_valid_q;
  assign r_opc_o   = r_opc_q;
  assign r_id_o    = r_id_q;
  assign r_rdata_o = r_rdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
// Directed bench for lockstep_mode_ctrl: bus handshake, enter/exit sequencing, timeouts,
// command legality, ERRCNT saturation and asynchronous reset.
module tb_lockstep_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be_s = '0;
  logic [1:0]  id_s = '0;
  logic        gnt, r_valid, r_opc, mode, irq;
  logic [1:0]  r_id;
  logic [31:0] r_rdata;
  logic [7:0]  barrier = '0;
  logic [3:0]  pairs;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  id_ctr = 2'd1;

  lockstep_mode_ctrl dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_i             (req),
    .add_i             (add),
    .wen_i             (wen),
    .wdata_i           (wdata),
    .be_i              (be_s),
    .id_i              (id_s),
    .gnt_o             (gnt),
    .r_valid_o         (r_valid),
    .r_opc_o           (r_opc),
    .r_id_o            (r_id),
    .r_rdata_o         (r_rdata),
    .barrier_matched_i (barrier),
    .lockstep_mode_o   (mode),
    .lockstep_pairs_o  (pairs),
    .irq_o             (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transfer, started and finished on a falling edge; checks grant and response framing.
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic [31:0] data,
                      input logic [3:0] be, output logic [31:0] rdata, output logic opc);
    logic [1:0] id;
    id = id_ctr;
    id_ctr = id_ctr + 2'd1;
    req = 1'b1; add = addr; wen = rd; wdata = data; be_s = be; id_s = id;
    #1 check("gnt", {31'd0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0; wen = 1'b0; wdata = '0; be_s = '0;
    check("r_valid", {31'd0, r_valid}, 32'd1);
    check("r_id", {30'd0, r_id}, {30'd0, id});
    rdata = r_rdata;
    opc = r_opc;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                    input logic exp_opc, input string tag);
    logic [31:0] rd_v;
    logic        opc_v;
    xfer(addr, 1'b0, data, be, rd_v, opc_v);
    check({tag, ".opc"}, {31'd0, opc_v}, {31'd0, exp_opc});
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_opc,
                    input string tag);
    logic [31:0] rd_v;
    logic        opc_v;
    xfer(addr, 1'b1, 32'd0, 4'hF, rd_v, opc_v);
    check({tag, ".rdata"}, rd_v, exp_data);
    check({tag, ".opc"}, {31'd0, opc_v}, {31'd0, exp_opc});
  endtask

  task automatic check_outs(input string tag, input logic [3:0] exp_pairs, input logic exp_mode,
                            input logic exp_irq);
    check({tag, ".pairs"}, {28'd0, pairs}, {28'd0, exp_pairs});
    check({tag, ".mode"}, {31'd0, mode}, {31'd0, exp_mode});
    check({tag, ".irq"}, {31'd0, irq}, {31'd0, exp_irq});
  endtask

  initial begin
    // Reset state and first read
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("reset", 4'h0, 1'b0, 1'b0);
    check("reset.r_valid", {31'd0, r_valid}, 32'd0);
    req = 1'b1; add = 32'h04; wen = 1'b1; be_s = 4'hF; id_s = 2'd2;
    #1 check("rd0.gnt", {31'd0, gnt}, 32'd1);
    check("rd0.r_valid_early", {31'd0, r_valid}, 32'd0);
    @(negedge clk);
    req = 1'b0; wen = 1'b0;
    check("rd0.r_valid", {31'd0, r_valid}, 32'd1);
    check("rd0.r_id", {30'd0, r_id}, 32'd2);
    check("rd0.rdata", r_rdata, 32'd0);
    check("rd0.opc", {31'd0, r_opc}, 32'd0);
    @(negedge clk);
    check("rd0.r_valid_drop", {31'd0, r_valid}, 32'd0);

    // ENTER pairs 0,1; unmasked-only flags do not match; full match locks next cycle
    wr(32'h00, 32'h0000_0301, 4'hF, 1'b0, "enter01");
    rd(32'h04, 32'h0000_0301, 1'b0, "status_sync_in");
    barrier = 8'hF7;
    @(negedge clk);
    check_outs("partial_match", 4'h0, 1'b0, 1'b0);
    barrier = 8'h00;
    @(negedge clk);
    barrier = 8'h0F;
    #1 check_outs("before_match", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    barrier = 8'h00;
    check_outs("locked01", 4'h3, 1'b1, 1'b0);

    // EXIT with core 0 missing, TIMEOUT=10 -> back to LOCKED after 10 wait cycles
    wr(32'h08, 32'd10, 4'hF, 1'b0, "timeout10");
    wr(32'h00, 32'h0000_0002, 4'hF, 1'b0, "exit01");
    barrier = 8'h0E;
    rd(32'h04, 32'h0000_0303, 1'b0, "status_sync_out");
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      check_outs("sync_out_wait", 4'h3, 1'b1, 1'b0);
    end
    @(negedge clk);
    check_outs("timeout_irq", 4'h3, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("timeout_irq_end", 4'h3, 1'b1, 1'b0);
    barrier = 8'h00;
    rd(32'h04, 32'h0000_0302, 1'b0, "status_back_locked");
    rd(32'h0C, 32'd1, 1'b0, "errcnt1");

    // Illegal commands
    wr(32'h00, 32'h0000_0301, 4'hF, 1'b1, "enter_in_locked");
    rd(32'h04, 32'h0000_0302, 1'b0, "status_after_bad_enter");
    wr(32'h00, 32'h0000_0002, 4'hF, 1'b0, "exit01_again");
    barrier = 8'h0F;
    @(negedge clk);
    barrier = 8'h00;
    check_outs("unlocked", 4'h0, 1'b0, 1'b0);
    rd(32'h04, 32'h0000_0300, 1'b0, "status_idle_mask_kept");
    wr(32'h00, 32'h0000_0302, 4'hF, 1'b1, "exit_in_idle");
    wr(32'h00, 32'h0000_0303, 4'hF, 1'b1, "enter_and_exit");
    wr(32'h00, 32'h0000_0001, 4'hF, 1'b1, "enter_mask0");
    rd(32'h04, 32'h0000_0300, 1'b0, "status_after_bad");
    wr(32'h00, 32'h0000_0F00, 4'hF, 1'b0, "ctrl_noop");
    rd(32'h00, 32'h0, 1'b0, "ctrl_read");
    rd(32'h20, 32'h0, 1'b1, "bad_addr_rd");
    wr(32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, "bad_addr_wr");
    rd(32'h04, 32'h0000_0300, 1'b0, "status_after_bad_addr");

    // Byte-enabled TIMEOUT write, then match exactly on the 4th wait cycle
    wr(32'h08, 32'h0000_AB04, 4'h1, 1'b0, "timeout_be");
    rd(32'h08, 32'h0000_0004, 1'b0, "timeout_rd");
    wr(32'h00, 32'h0000_0401, 4'hF, 1'b0, "enter2");
    barrier = 8'h0F;
    repeat (3) @(negedge clk);
    barrier = 8'h30;
    @(negedge clk);
    barrier = 8'h00;
    check_outs("match_on_timeout", 4'h4, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("match_on_timeout_next", 4'h4, 1'b1, 1'b0);
    rd(32'h0C, 32'd1, 1'b0, "errcnt_unchanged");
    wr(32'h00, 32'h0000_0002, 4'hF, 1'b0, "exit2");
    barrier = 8'h30;
    @(negedge clk);
    barrier = 8'h00;
    check_outs("unlocked2", 4'h0, 1'b0, 1'b0);

    // 300 SYNC_IN timeouts -> ERRCNT saturates; any write clears it
    wr(32'h08, 32'd1, 4'h3, 1'b0, "timeout1");
    for (int i = 0; i < 300; i++) begin
      wr(32'h00, 32'h0000_0101, 4'hF, 1'b0, "enter_to");
      @(negedge clk);
      check_outs("sync_in_timeout", 4'h0, 1'b0, 1'b1);
    end
    rd(32'h04, 32'h0000_0100, 1'b0, "status_after_to");
    rd(32'h0C, 32'd255, 1'b0, "errcnt_sat");
    wr(32'h0C, 32'h0000_1234, 4'h0, 1'b0, "errcnt_clr");
    rd(32'h0C, 32'd0, 1'b0, "errcnt_zero");

    // Asynchronous reset while in SYNC_OUT
    wr(32'h08, 32'h0000_1234, 4'hF, 1'b0, "timeout_big");
    wr(32'h00, 32'h0000_0101, 4'hF, 1'b0, "enter0");
    barrier = 8'h03;
    @(negedge clk);
    barrier = 8'h00;
    check_outs("locked0", 4'h1, 1'b1, 1'b0);
    wr(32'h00, 32'h0000_0002, 4'hF, 1'b0, "exit0");
    rd(32'h04, 32'h0000_0103, 1'b0, "status_sync_out0");
    check_outs("sync_out0", 4'h1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outs("async_reset", 4'h0, 1'b0, 1'b0);
    check("async_reset.r_valid", {31'd0, r_valid}, 32'd0);
    check("async_reset.r_rdata", r_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h04, 32'h0, 1'b0, "status_after_reset");
    rd(32'h08, 32'h0, 1'b0, "timeout_after_reset");
    rd(32'h0C, 32'h0, 1'b0, "errcnt_after_reset");
    check_outs("after_reset", 4'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lockstep_mode_ctrl.md
Name: lockstep_mode_ctrl

Overview:
- Register-programmed sequencer that moves core pairs of the cluster into and out of lockstep execution.
- Slave on the cluster peripheral interconnect (XBAR_PERIPH_BUS protocol).
- Gates each mode change on the per-core event-unit barrier-match flags, so paired cores switch only at a common synchronisation point.
- Drives the lockstep enables consumed by the cluster lockstep unit, plus an error interrupt on sync timeout.

Parameters:
- NUM_CORES, 8, cluster cores; even, 2..16.
- NUM_PAIRS, NUM_CORES/2, derived lockstep pairs; pair p = cores 2p and 2p+1.
- ID_WIDTH, 2, width of the peripheral transaction id.
- TO_WIDTH, 16, timeout counter width.

Ports:
- clk_i  in  1  cluster clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  peripheral request.
- add_i  in  32  byte address; only [5:2] decoded.
- wen_i  in  1  1=read, 0=write.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables.
- id_i  in  ID_WIDTH  transaction id.
- gnt_o  out  1  grant.
- r_valid_o  out  1  response valid.
- r_opc_o  out  1  0=ok, 1=error.
- r_id_o  out  ID_WIDTH  echoed id.
- r_rdata_o  out  32  read data.
- barrier_matched_i  in  NUM_CORES  per-core barrier-match flags from the event unit.
- lockstep_mode_o  out  1  high while any pair is locked.
- lockstep_pairs_o  out  NUM_PAIRS  per-pair lockstep enable.
- irq_o  out  1  one-cycle pulse on sync timeout.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM IDLE; MASK=0, TIMEOUT=0, ERRCNT=0, counter 0.
- Bus handshake:
  - gnt_o = req_i combinationally; every request is granted.
  - Response exactly 1 cycle later: r_valid_o=1 for one cycle, with r_id_o = registered id_i.
  - Writes update registers in the grant cycle.
  - Byte enables apply to TIMEOUT only; other registers act on any write.
- Register map (byte offsets):
  - 0x00 CTRL (W): bit0 ENTER, bit1 EXIT, [NUM_PAIRS+7:8] pair mask. Reads return 0.
  - 0x04 STATUS (R): [1:0] state (IDLE=0, SYNC_IN=1, LOCKED=2, SYNC_OUT=3), [NUM_PAIRS+7:8] MASK.
  - 0x08 TIMEOUT (RW): [TO_WIDTH-1:0] cycle limit; 0 disables timeout.
  - 0x0C ERRCNT (RW): [7:0] saturating timeout count; any write clears it.
  - Other offsets: r_opc_o=1, r_rdata_o=0, no side effects.
- Command legality:
  - ENTER is legal only in IDLE with a nonzero mask.
  - EXIT is legal only in LOCKED.
  - ENTER and EXIT both set is illegal.
  - An illegal CTRL write gets r_opc_o=1 and causes no state change.
  - Writing CTRL with both bits 0 is a legal no-op.
- FSM:
  - IDLE -ENTER-> SYNC_IN: latch the mask, clear the counter.
  - SYNC_IN -> LOCKED when every core of every masked pair has barrier_matched_i=1 in the same cycle.
    - lockstep_pairs_o=MASK and lockstep_mode_o=1 from the next cycle.
  - LOCKED -EXIT-> SYNC_OUT: clear the counter; outputs stay asserted.
  - SYNC_OUT -> IDLE on the same match condition.
    - Outputs drop to 0 the next cycle; MASK is retained for STATUS.
- Timeout:
  - In SYNC states the counter increments every cycle without a match.
  - When the counter equals a nonzero TIMEOUT:
    - SYNC_IN returns to IDLE; SYNC_OUT returns to LOCKED.
    - ERRCNT increments, saturating at 255.
    - irq_o pulses for 1 cycle.
  - If match and timeout occur in the same cycle, match wins and there is no error.
  - A TIMEOUT write during a SYNC state takes effect immediately against the live counter.
  - A counter already beyond the new value does not fire until it wraps at 2^TO_WIDTH.
  - The counter holds at 0 outside SYNC states.
- Unmasked cores' barrier flags are ignored.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronous).

Test Plan:
- Reset, read 0x04 -> rdata 0, r_opc 0, r_valid one cycle after gnt, r_id echoed.
- Write 0x00 = 0x0301 (pairs 0,1, ENTER); hold barrier_matched_i=0x0F for 1 cycle after 3 idle cycles -> STATUS=1 during the wait; lockstep_pairs_o=0b0011 and lockstep_mode_o=1 the cycle after the match.
- From LOCKED, write EXIT; barrier 0x0E only (core 0 missing) with TIMEOUT=10 -> after 10 cycles state LOCKED, irq_o single pulse, ERRCNT=1, outputs still 0b0011.
- In LOCKED, write ENTER; in IDLE, write EXIT; write 0x0003; write mask 0 with ENTER -> each gets r_opc=1 with state unchanged. Read 0x20 -> r_opc=1, rdata 0.
- TIMEOUT=4, match arriving exactly on the 4th wait cycle -> transition taken, no irq, ERRCNT unchanged. Force 300 timeouts -> ERRCNT=255; write 0x0C -> 0.
- Assert rst_ni low while in SYNC_OUT -> all outputs 0 asynchronously; after release STATUS=0 and TIMEOUT=0.
